// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract/compare unit.
package addsub_pkg;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_CMP  = 2'd2;
  localparam logic [1:0] OP_ADDC = 2'd3;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
    logic eq;
    logic lt_u;
    logic lt_s;
  } flags_t;

  // SUB and CMP share the inverted-operand datapath and the compare flags
  function automatic logic is_sub_op(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/addsub_cmp_pipe_if.sv
// Operand/result valid-ready stream bundle for addsub_cmp_pipe.
interface addsub_cmp_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;
  logic             out_eq;
  logic             out_lt_u;
  logic             out_lt_s;
  logic [1:0]       out_op;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
    input  in_ready, out_valid, out_res, out_carry, out_ovf, out_zero,
           out_neg, out_eq, out_lt_u, out_lt_s, out_op
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
    output in_ready, out_valid, out_res, out_carry, out_ovf, out_zero,
           out_neg, out_eq, out_lt_u, out_lt_s, out_op
  );
endinterface

// File: rtl/addsub_slice.sv
// One CHUNK-bit pipeline stage: slice adder plus registered carry, running zero and valid.
module addsub_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic             zin,
  output logic [CHUNK-1:0] sum_c,
  output logic             cout_c,
  output logic             zero_c,
  output logic             v_q,
  output logic             cout_q,
  output logic             zero_q
);
  localparam int unsigned CW = CHUNK + 1;

  logic [CHUNK:0] full_c;

  assign full_c = {1'b0, a} + {1'b0, b} + CW'(cin);
  assign sum_c  = full_c[CHUNK-1:0];
  assign cout_c = full_c[CHUNK];
  assign zero_c = zin && (sum_c == '0);

  // Whole stage holds under global stall; bubbles clear the valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      v_q    <= vin;
      cout_q <= cout_c;
      zero_q <= zero_c;
    end
  end
endmodule

// File: rtl/addsub_cmp_pipe.sv
// Pipelined two's-complement add/sub/compare: one CHUNK-bit slice per stage, carry rippled through registers.
module addsub_cmp_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 8
) (
  input logic               clk,
  input logic               rst_n,
  addsub_cmp_pipe_if.slave  bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'({CHUNK{1'b1}});

  // Operand words rotate right by CHUNK each stage, so the slice to process is
  // always in the low chunk and the finished result lands back in place.
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x);
    return (x >> CHUNK) | (x << (WIDTH - CHUNK));
  endfunction

  logic             stall;
  logic             en;
  logic [WIDTH-1:0] a_i [STAGES];
  logic [WIDTH-1:0] b_i [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [1:0]       op_i[STAGES];
  logic [1:0]       op_q[STAGES];
  logic             c_i [STAGES];
  logic             z_i [STAGES];
  logic             v_i [STAGES];
  logic [CHUNK-1:0] sum_c [STAGES];
  logic             cout_c[STAGES];
  logic             zero_c[STAGES];
  logic             cout_q[STAGES];
  logic             zero_q[STAGES];
  logic             v_q   [STAGES];
  flags_t           flags_c;
  flags_t           flags_q;

  assign stall        = v_q[LAST] && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = !stall;

  // Stage inputs: effective operands at the front, previous stage registers behind
  always_comb begin
    a_i[0]  = bus.in_a;
    b_i[0]  = is_sub_op(bus.in_op) ? ~bus.in_b : bus.in_b;
    op_i[0] = bus.in_op;
    c_i[0]  = is_sub_op(bus.in_op) ? 1'b1 : ((bus.in_op == OP_ADDC) ? bus.in_cin : 1'b0);
    z_i[0]  = 1'b1;
    v_i[0]  = bus.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_i[k]  = a_q[k-1];
      b_i[k]  = b_q[k-1];
      op_i[k] = op_q[k-1];
      c_i[k]  = cout_q[k-1];
      z_i[k]  = zero_q[k-1];
      v_i[k]  = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .vin    (v_i[k]),
      .a      (a_i[k][CHUNK-1:0]),
      .b      (b_i[k][CHUNK-1:0]),
      .cin    (c_i[k]),
      .zin    (z_i[k]),
      .sum_c  (sum_c[k]),
      .cout_c (cout_c[k]),
      .zero_c (zero_c[k]),
      .v_q    (v_q[k]),
      .cout_q (cout_q[k]),
      .zero_q (zero_q[k])
    );
  end

  // Operand skew: the processed low chunk of A is replaced by its result slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        op_q[k] <= '0;
      end
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]  <= rotr((a_i[k] & ~LOW_MASK) | WIDTH'(sum_c[k]));
        b_q[k]  <= rotr(b_i[k]);
        op_q[k] <= op_i[k];
      end
    end
  end

  // Last stage sees the operand MSBs in the low chunk of its input words
  always_comb begin
    flags_c       = '0;
    flags_c.carry = cout_c[LAST];
    flags_c.zero  = zero_c[LAST];
    flags_c.neg   = sum_c[LAST][CHUNK-1];
    flags_c.ovf   = (a_i[LAST][CHUNK-1] == b_i[LAST][CHUNK-1]) &&
                    (sum_c[LAST][CHUNK-1] != a_i[LAST][CHUNK-1]);
    if (is_sub_op(op_i[LAST])) begin
      flags_c.eq   = flags_c.zero;
      flags_c.lt_u = !flags_c.carry;
      flags_c.lt_s = flags_c.neg ^ flags_c.ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (en) begin
      flags_q <= flags_c;
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.out_res   = a_q[LAST];
  assign bus.out_op    = op_q[LAST];
  assign bus.out_carry = flags_q.carry;
  assign bus.out_ovf   = flags_q.ovf;
  assign bus.out_zero  = flags_q.zero;
  assign bus.out_neg   = flags_q.neg;
  assign bus.out_eq    = flags_q.eq;
  assign bus.out_lt_u  = flags_q.lt_u;
  assign bus.out_lt_s  = flags_q.lt_s;
endmodule

// File: tb/tb_addsub_cmp_pipe.sv
// Scoreboard bench for addsub_cmp_pipe at 16/8, 32/8 and 16/16.
module tb_addsub_cmp_pipe;
  import addsub_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_cmp_pipe_if #(.WIDTH(16)) if16 ();
  addsub_cmp_pipe_if #(.WIDTH(32)) if32 ();
  addsub_cmp_pipe_if #(.WIDTH(16)) if1  ();

  addsub_cmp_pipe #(.WIDTH(16), .CHUNK(8))  u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  addsub_cmp_pipe #(.WIDTH(32), .CHUNK(8))  u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  addsub_cmp_pipe #(.WIDTH(16), .CHUNK(16)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
  } beat_t;

  typedef struct packed {
    logic [31:0] res;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic        eq;
    logic        lt_u;
    logic        lt_s;
    logic [1:0]  op;
  } exp_t;

  int    checks   = 0;
  int    failures = 0;
  beat_t stim[$];
  exp_t  sbq[$];
  exp_t  got_log[$];

  // Reference from integer arithmetic: signed range test for ovf, direct compares for eq/lt
  function automatic exp_t model(input int w, input beat_t bt);
    exp_t        e;
    logic [63:0] mask, aa, bb, beff, s;
    logic        sub, c;
    longint      sa, sb, sr, lo, hi;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, bt.a} & mask;
    bb   = {32'd0, bt.b} & mask;
    sub  = (bt.op == OP_SUB) || (bt.op == OP_CMP);
    beff = sub ? (~bb & mask) : bb;
    c    = sub ? 1'b1 : ((bt.op == OP_ADDC) ? bt.cin : 1'b0);
    s    = aa + beff + {63'd0, c};
    sa   = aa[w-1] ? longint'(aa | ~mask) : longint'(aa);
    sb   = bb[w-1] ? longint'(bb | ~mask) : longint'(bb);
    sr   = sub ? (sa - sb) : (sa + sb + longint'({63'd0, c}));
    lo   = -(longint'(1) << (w - 1));
    hi   = (longint'(1) << (w - 1)) - 1;
    e.res   = 32'(s & mask);
    e.carry = s[w];
    e.zero  = ((s & mask) == 64'd0);
    e.neg   = s[w-1];
    e.ovf   = (sr < lo) || (sr > hi);
    e.eq    = sub && (aa == bb);
    e.lt_u  = sub && (aa < bb);
    e.lt_s  = sub && (sa < sb);
    e.op    = bt.op;
    return e;
  endfunction

  // Drives queued beats into the 16/8 unit with an optional out_ready=0 window and scoreboards the results
  task automatic run16(input int stall_at, input int stall_len, input int exp_lat);
    int   cyc = 0;
    int   acc[$];
    int   lat;
    logic held = 1'b0;
    logic [15:0] held_res = '0;
    logic [1:0]  held_op = '0;
    exp_t e, got;
    got_log.delete();
    while ((stim.size() != 0 || sbq.size() != 0) && cyc < 200) begin
      @(negedge clk);
      if16.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (stim.size() != 0) begin
        if16.in_valid = 1'b1;
        if16.in_a     = stim[0].a[15:0];
        if16.in_b     = stim[0].b[15:0];
        if16.in_op    = stim[0].op;
        if16.in_cin   = stim[0].cin;
      end else begin
        if16.in_valid = 1'b0;
      end
      #1;
      checks++;
      if (if16.in_ready !== !(if16.out_valid && !if16.out_ready)) begin
        failures++;
        $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, if16.in_ready,
                 !(if16.out_valid && !if16.out_ready));
      end
      if (held) begin
        checks++;
        if (if16.out_valid !== 1'b1 || if16.out_res !== held_res || if16.out_op !== held_op) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got=%b/%h/%0d exp=1/%h/%0d", cyc, if16.out_valid,
                   if16.out_res, if16.out_op, held_res, held_op);
        end
      end
      held     = if16.out_valid && !if16.out_ready;
      held_res = if16.out_res;
      held_op  = if16.out_op;
      if (if16.out_valid && if16.out_ready) begin
        got = '{res: {16'd0, if16.out_res}, carry: if16.out_carry, ovf: if16.out_ovf,
                zero: if16.out_zero, neg: if16.out_neg, eq: if16.out_eq, lt_u: if16.out_lt_u,
                lt_s: if16.out_lt_s, op: if16.out_op};
        got_log.push_back(got);
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat cyc=%0d got=%h exp=none", cyc, got);
        end else begin
          e   = sbq.pop_front();
          lat = cyc - acc.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL result cyc=%0d got=%h exp=%h", cyc, got, e);
          end
          if (exp_lat >= 0) begin
            checks++;
            if (lat != exp_lat) begin
              failures++;
              $display("FAIL latency cyc=%0d got=%0d exp=%0d", cyc, lat, exp_lat);
            end
          end
        end
      end
      if (if16.in_valid && if16.in_ready) begin
        sbq.push_back(model(16, stim.pop_front()));
        acc.push_back(cyc);
      end
      cyc++;
    end
    if (stim.size() != 0 || sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout pending_in=%0d pending_out=%0d exp=0/0", stim.size(), sbq.size());
      stim.delete();
      sbq.delete();
    end
    @(negedge clk);
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({if16.out_valid, if16.out_res, if16.out_carry, if16.out_ovf, if16.out_zero, if16.out_neg,
         if16.out_eq, if16.out_lt_u, if16.out_lt_s, if16.out_op, if16.in_ready} !== 27'd1) begin
      failures++;
      $display("FAIL reset_state got v=%b res=%h op=%0d rdy=%b exp v=0 res=0 op=0 rdy=1",
               if16.out_valid, if16.out_res, if16.out_op, if16.in_ready);
    end
    checks++;
    if (if32.out_valid !== 1'b0 || if1.out_valid !== 1'b0 || if32.out_res !== 32'd0) begin
      failures++;
      $display("FAIL reset_other got v32=%b v1=%b res32=%h exp 0/0/0", if32.out_valid,
               if1.out_valid, if32.out_res);
    end
  endtask

  task automatic test_add_ovf();
    exp_t want;
    stim.push_back('{a: 32'h7FFF, b: 32'h0001, op: OP_ADD, cin: 1'b0});
    run16(1000, 0, 2);
    want = '{res: 32'h8000, carry: 1'b0, ovf: 1'b1, zero: 1'b0, neg: 1'b1,
             eq: 1'b0, lt_u: 1'b0, lt_s: 1'b0, op: OP_ADD};
    checks++;
    if (got_log.size() != 1 || got_log[0] !== want) begin
      failures++;
      $display("FAIL add_ovf_const n=%0d got=%h exp=%h", got_log.size(),
               (got_log.size() != 0) ? got_log[0] : '0, want);
    end
  endtask

  task automatic test_sub_cmp();
    exp_t want[4];
    stim.push_back('{a: 32'h0003, b: 32'h0005, op: OP_SUB,  cin: 1'b0});
    stim.push_back('{a: 32'h8000, b: 32'h0001, op: OP_CMP,  cin: 1'b0});
    stim.push_back('{a: 32'hFFFF, b: 32'h0000, op: OP_ADDC, cin: 1'b1});
    stim.push_back('{a: 32'h1234, b: 32'h1234, op: OP_CMP,  cin: 1'b0});
    run16(1000, 0, 2);
    want[0] = '{res: 32'hFFFE, carry: 0, ovf: 0, zero: 0, neg: 1, eq: 0, lt_u: 1, lt_s: 1, op: OP_SUB};
    want[1] = '{res: 32'h7FFF, carry: 1, ovf: 1, zero: 0, neg: 0, eq: 0, lt_u: 0, lt_s: 1, op: OP_CMP};
    want[2] = '{res: 32'h0000, carry: 1, ovf: 0, zero: 1, neg: 0, eq: 0, lt_u: 0, lt_s: 0, op: OP_ADDC};
    want[3] = '{res: 32'h0000, carry: 1, ovf: 0, zero: 1, neg: 0, eq: 1, lt_u: 0, lt_s: 0, op: OP_CMP};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_log.size() || got_log[i] !== want[i]) begin
        failures++;
        $display("FAIL sub_cmp_const beat=%0d got=%h exp=%h", i,
                 (i < got_log.size()) ? got_log[i] : '0, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      stim.push_back('{a: 32'(16'h1111 * (i + 1)), b: 32'(16'h0101 * (i + 3)),
                       op: 2'(i), cin: 1'(i)});
    run16(3, 3, -1);
    checks++;
    if (got_log.size() != 4) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=4", got_log.size());
    end
    for (int i = 0; i < 24; i++)
      stim.push_back('{a: 32'($urandom_range(0, 65535)), b: 32'($urandom_range(0, 65535)),
                       op: 2'($urandom_range(0, 3)), cin: 1'($urandom_range(0, 1))});
    run16(8, 4, -1);
    checks++;
    if (got_log.size() != 24) begin
      failures++;
      $display("FAIL random_count got=%0d exp=24", got_log.size());
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (if16.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_drain got=%b exp=0", if16.out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic stale = 1'b0;
    @(negedge clk);
    if16.out_ready = 1'b1;
    if16.in_valid  = 1'b1;
    if16.in_a = 16'h0100; if16.in_b = 16'h0001; if16.in_op = OP_ADD; if16.in_cin = 1'b0;
    @(negedge clk);
    if16.in_a = 16'h0200; if16.in_b = 16'h0002; if16.in_op = OP_SUB;
    @(negedge clk);
    if16.in_valid = 1'b0;
    #1;
    checks++;
    if (if16.out_valid !== 1'b1 || if16.out_res !== 16'h0101) begin
      failures++;
      $display("FAIL pre_reset_beat got=%b/%h exp=1/0101", if16.out_valid, if16.out_res);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if16.out_valid !== 1'b0 || if16.out_res !== 16'h0000 || if16.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got=%b/%h/%b exp=0/0000/1", if16.out_valid, if16.out_res,
               if16.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (if16.out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL stale_after_reset got=1 exp=0");
    end
  endtask

  task automatic test_cfg32();
    beat_t bts[3];
    exp_t  e, got, want;
    int    lat;
    bts[0] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, op: OP_ADD, cin: 1'b0};
    bts[1] = '{a: 32'h0000_0005, b: 32'h0000_0007, op: OP_SUB, cin: 1'b0};
    bts[2] = '{a: 32'h8000_0000, b: 32'h0000_0001, op: OP_CMP, cin: 1'b0};
    want   = '{res: 32'h8000_0000, carry: 0, ovf: 1, zero: 0, neg: 1, eq: 0, lt_u: 0, lt_s: 0,
               op: OP_ADD};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if32.out_ready = 1'b1;
      if32.in_valid  = 1'b1;
      if32.in_a = bts[i].a; if32.in_b = bts[i].b; if32.in_op = bts[i].op; if32.in_cin = bts[i].cin;
      #1;
      checks++;
      if (if32.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL w32_in_ready got=%b exp=1", if32.in_ready);
      end else sbq.push_back(model(32, bts[i]));
      @(negedge clk);
      if32.in_valid = 1'b0;
      lat = 1;
      #1;
      while (if32.out_valid !== 1'b1 && lat < 12) begin
        @(negedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat != 4) begin
        failures++;
        $display("FAIL w32_latency beat=%0d got=%0d exp=4", i, lat);
      end
      got = '{res: if32.out_res, carry: if32.out_carry, ovf: if32.out_ovf, zero: if32.out_zero,
              neg: if32.out_neg, eq: if32.out_eq, lt_u: if32.out_lt_u, lt_s: if32.out_lt_s,
              op: if32.out_op};
      e = (sbq.size() != 0) ? sbq.pop_front() : '1;
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL w32_result beat=%0d got=%h exp=%h", i, got, e);
      end
      if (i == 0) begin
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL w32_add_const got=%h exp=%h", got, want);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (if32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL w32_drain got=%b exp=0", if32.out_valid);
    end
  endtask

  task automatic test_cfg16x16();
    beat_t bts[3];
    exp_t  e, got, want;
    int    lat;
    bts[0] = '{a: 32'h7FFF, b: 32'h0001, op: OP_ADD,  cin: 1'b0};
    bts[1] = '{a: 32'h0003, b: 32'h0005, op: OP_SUB,  cin: 1'b0};
    bts[2] = '{a: 32'hFFFF, b: 32'h0000, op: OP_ADDC, cin: 1'b1};
    want   = '{res: 32'h8000, carry: 0, ovf: 1, zero: 0, neg: 1, eq: 0, lt_u: 0, lt_s: 0,
               op: OP_ADD};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if1.out_ready = 1'b1;
      if1.in_valid  = 1'b1;
      if1.in_a = bts[i].a[15:0]; if1.in_b = bts[i].b[15:0]; if1.in_op = bts[i].op;
      if1.in_cin = bts[i].cin;
      #1;
      checks++;
      if (if1.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL w16c16_in_ready got=%b exp=1", if1.in_ready);
      end else sbq.push_back(model(16, bts[i]));
      @(negedge clk);
      if1.in_valid = 1'b0;
      lat = 1;
      #1;
      while (if1.out_valid !== 1'b1 && lat < 12) begin
        @(negedge clk);
        #1;
        lat++;
      end
      checks++;
      if (lat != 1) begin
        failures++;
        $display("FAIL w16c16_latency beat=%0d got=%0d exp=1", i, lat);
      end
      got = '{res: {16'd0, if1.out_res}, carry: if1.out_carry, ovf: if1.out_ovf,
              zero: if1.out_zero, neg: if1.out_neg, eq: if1.out_eq, lt_u: if1.out_lt_u,
              lt_s: if1.out_lt_s, op: if1.out_op};
      e = (sbq.size() != 0) ? sbq.pop_front() : '1;
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL w16c16_result beat=%0d got=%h exp=%h", i, got, e);
      end
      if (i == 0) begin
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL w16c16_add_const got=%h exp=%h", got, want);
        end
      end
    end
  endtask

  initial begin
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_op = '0; if16.in_cin = 1'b0;
    if16.out_ready = 1'b1;
    if32.in_valid = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_op = '0; if32.in_cin = 1'b0;
    if32.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.in_op = '0; if1.in_cin = 1'b0;
    if1.out_ready = 1'b1;
    test_reset();
    test_add_ovf();
    test_sub_cmp();
    test_back_to_back();
    test_reset_midflight();
    test_cfg32();
    test_cfg16x16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addsub_cmp_pipe.md
# addsub_cmp_pipe

Parametrised, pipelined two's-complement add/subtract/compare unit with a valid/ready stream interface. The WIDTH-bit datapath is split into CHUNK-bit slices, one slice per pipeline stage, with carry registered between stages. The block produces the sum/difference plus carry, overflow, zero, negative and signed/unsigned compare flags. It is the datapath ALU's arithmetic and compare engine, replacing the single-cycle 16-bit combinational adder/subtractor.

## Interface
- WIDTH, 16, operand/result width; must be ≥2 and a multiple of CHUNK
- CHUNK, 8, bits per pipeline stage; STAGES = WIDTH/CHUNK (latency)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  2  operation: 0 ADD, 1 SUB, 2 CMP, 3 ADDC
- in_cin  in  1  carry-in, used only by ADDC
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_res  out  WIDTH  sum/difference
- out_carry  out  1  carry out of MSB (for SUB/CMP: 1 = no borrow)
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_res == 0
- out_neg  out  1  out_res[WIDTH-1]
- out_eq  out  1  A == B (SUB/CMP only, else 0)
- out_lt_u  out  1  A < B unsigned (SUB/CMP only, else 0)
- out_lt_s  out  1  A < B signed (SUB/CMP only, else 0)
- out_op  out  2  op of this result beat

## Operation
- Effective B: SUB/CMP use ~in_b with carry-in 1; ADD uses in_b with carry-in 0; ADDC uses in_b with carry-in in_cin.
- Stage k (k = 0..STAGES-1) adds slice k of A and effective B plus the incoming carry. It registers its result slice, the carry out, and a running zero flag (AND of per-slice zero). Higher slices of A/effective B travel down the stage registers unprocessed (operand skew).
- The last stage computes the flags:
  - ovf = (A_msb == Beff_msb) && (res_msb != A_msb)
  - neg = res_msb; carry = final carry out
  - For SUB/CMP: eq = zero, lt_u = ~carry, lt_s = neg ^ ovf. For ADD/ADDC: eq = lt_u = lt_s = 0.
- CMP is identical to SUB in datapath and flags. out_op lets the consumer drop out_res for CMP.
- All arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Handshake: a beat transfers when valid && ready on the same edge. in_valid/in_a/in_b/in_op/in_cin must be held stable by the source until accepted. Once out_valid is asserted, out_* stay stable until out_ready.
- Global stall: stall = out_valid && !out_ready. While stall is asserted, every stage holds, and in_ready = !stall, combinational.
- Bubbles advance freely when not stalled. A stage's valid bit clears when nothing enters it.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Simultaneous accept of the output and a new input in the same cycle must be supported without bubble insertion.
- Reset (async assert, sync deassert by the system):
  - All stage valid bits cleared; in-flight beats are discarded, never emitted.
  - out_valid=0, out_res=0, all flags 0, out_op=0. in_ready=1 from the first cycle after reset.
- STAGES=1 (CHUNK=WIDTH) degenerates to a single registered stage with latency 1.

## Structure
- Package addsub_pkg:
  - op encoding constants OP_ADD/OP_SUB/OP_CMP/OP_ADDC
  - packed flags struct {carry, ovf, zero, neg, eq, lt_u, lt_s}
- Sub-module addsub_slice: one CHUNK-bit stage (adder + carry/zero/valid register with hold enable), instantiated STAGES times by a generate loop.
- The top level contains the operand skew registers, the flag logic in the last stage, and the stall/ready logic.

## Test plan
All scenarios use WIDTH=16, CHUNK=8 unless stated.
- ADD 0x7FFF + 0x0001 → out_res 0x8000, ovf=1, neg=1, carry=0, zero=0; out_valid exactly 2 cycles after accept.
- SUB 0x0003 − 0x0005 → 0xFFFE, carry=0, lt_u=1, lt_s=1, eq=0, neg=1.
- CMP 0x8000 vs 0x0001 → out_res 0x7FFF, ovf=1, carry=1, lt_s=1, lt_u=0, eq=0, out_op=2.
- ADDC 0xFFFF + 0x0000 with cin=1 → 0x0000, carry=1, zero=1; CMP 0x1234 vs 0x1234 → eq=1, zero=1, lt_u=lt_s=0.
- Back-pressure: issue 4 back-to-back beats, hold out_ready=0 for 3 cycles mid-stream:
  - no beat is lost or duplicated, order is preserved;
  - in_ready=0 exactly while out_valid && !out_ready;
  - results are held stable while stalled.
- Reset mid-flight:
  - assert rst_n=0 with 2 beats in flight → out_valid=0 immediately and no stale beat after release.
  - Repeat the ADD check at WIDTH=32/CHUNK=8 (latency 4) and WIDTH=16/CHUNK=16 (latency 1).
